// File: rtl/divider_pkg.sv
// divider_pkg: width constants and reconstruction target shared with the divider
package divider_pkg;
  localparam int N = 6;
  localparam int M = 4;
  localparam int M_ACTIVE_MIN = 2;
  localparam int Q_W = N - M_ACTIVE_MIN + 1;
  localparam int P_W = Q_W + M;
  localparam logic [N-1:0] DIVIDEND_CONST = {N{1'b1}};
endpackage

// File: rtl/divider_recon_mul_stage.sv
// recon_mul_stage: one shift-add step adding merchant<<K when divisor bit K is set
module recon_mul_stage
  import divider_pkg::*;
#(
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           valid_prev,
  input  logic [P_W-1:0] acc_prev,
  input  logic [Q_W-1:0] merchant_prev,
  input  logic [M-1:0]   divisor_prev,
  output logic           valid,
  output logic [P_W-1:0] acc,
  output logic [Q_W-1:0] merchant,
  output logic [M-1:0]   divisor,
  output logic [P_W-1:0] sum
);
  assign sum = acc_prev + (divisor_prev[K] ? P_W'(merchant_prev) << K : '0);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      valid    <= 1'b0;
      acc      <= '0;
      merchant <= '0;
      divisor  <= '0;
    end else begin
      valid <= valid_prev;
      if (valid_prev) begin
        acc      <= sum;
        merchant <= merchant_prev;
        divisor  <= divisor_prev;
      end
    end
endmodule

// File: rtl/divider_recon_mul.sv
// divider_recon_mul: pipelined merchant*divisor+remainder, one divisor bit per stage.
// DIVIDER_RECON_CHECK_EN adds a registered compare against the divider's dividend constant.
module divider_recon_mul
  import divider_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  input  logic [Q_W-1:0] merchant,
  input  logic [M-1:0]   divisor,
  input  logic [M-1:0]   remainder,
  output logic           out_valid,
  output logic [P_W-1:0] dividend,
  output logic           check_err
);
  logic           vld [M];
  logic [P_W-1:0] acc [M];
  logic [Q_W-1:0] mer [M];
  logic [M-1:0]   div [M];
  logic [P_W-1:0] sum [1:M-1];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      vld[0] <= 1'b0;
      acc[0] <= '0;
      mer[0] <= '0;
      div[0] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        acc[0] <= P_W'(remainder) + (divisor[0] ? P_W'(merchant) : '0);
        mer[0] <= merchant;
        div[0] <= divisor;
      end
    end
  for (genvar k = 1; k < M; k++) begin : g_stage
    recon_mul_stage #(.K(k)) u_stage (
      .clk          (clk),
      .rstn         (rstn),
      .valid_prev   (vld[k-1]),
      .acc_prev     (acc[k-1]),
      .merchant_prev(mer[k-1]),
      .divisor_prev (div[k-1]),
      .valid        (vld[k]),
      .acc          (acc[k]),
      .merchant     (mer[k]),
      .divisor      (div[k]),
      .sum          (sum[k])
    );
  end
  assign out_valid = vld[M-1];
  assign dividend  = acc[M-1];
`ifdef DIVIDER_RECON_CHECK_EN
  // Compare the value entering the last stage so the flag lands with out_valid
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) check_err <= 1'b0;
    else       check_err <= vld[M-2] && (sum[M-1] != P_W'(DIVIDEND_CONST));
`else
  assign check_err = 1'b0;
`endif
endmodule

// File: tb/tb_divider_recon_mul.sv
// tb_divider_recon_mul: directed self-checking bench for divider_recon_mul
module tb_divider_recon_mul;
  import divider_pkg::*;
  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           in_valid = 1'b0;
  logic [Q_W-1:0] merchant = '0;
  logic [M-1:0]   divisor = '0;
  logic [M-1:0]   remainder = '0;
  logic           out_valid;
  logic [P_W-1:0] dividend;
  logic           check_err;
  int n_chk = 0;
  int n_fail = 0;
`ifdef DIVIDER_RECON_CHECK_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  divider_recon_mul dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .merchant (merchant),
    .divisor  (divisor),
    .remainder(remainder),
    .out_valid(out_valid),
    .dividend (dividend),
    .check_err(check_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int q, input int d, input int r);
    in_valid  = v;
    merchant  = Q_W'(q);
    divisor   = M'(d);
    remainder = M'(r);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b0, 0, 0, 0);
    step();
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_chk++; if (dividend !== '0) begin n_fail++; $display("FAIL reset_dividend got %0d want 0", dividend); end
    n_chk++; if (check_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", check_err); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    drive(1'b1, 21, 3, 0);
    step();
    drive(1'b0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early cyc%0d got %b want 0", i, out_valid); end
      step();
    end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_chk++; if (dividend !== 9'd63) begin n_fail++; $display("FAIL single_dividend got %0d want 63", dividend); end
    n_chk++; if (check_err !== 1'b0) begin n_fail++; $display("FAIL single_err got %b want 0", check_err); end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_after got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int q[3] = '{12, 4, 31};
    int d[3] = '{5, 15, 2};
    int r[3] = '{3, 3, 1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, q[i], d[i], r[i]);
      step();
    end
    drive(1'b0, 0, 0, 0);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid item%0d got %b want 1", i, out_valid); end
      n_chk++; if (dividend !== 9'd63) begin n_fail++; $display("FAIL b2b_dividend item%0d got %0d want 63", i, dividend); end
      n_chk++; if (check_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err item%0d got %b want 0", i, check_err); end
    end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_after got %b want 0", out_valid); end
  endtask

  task automatic test_max();
    drive(1'b1, 31, 15, 15);
    step();
    drive(1'b0, 0, 0, 0);
    repeat (3) step();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL max_valid got %b want 1", out_valid); end
    n_chk++; if (dividend !== 9'd480) begin n_fail++; $display("FAIL max_dividend got %0d want 480", dividend); end
    n_chk++; if (check_err !== CE) begin n_fail++; $display("FAIL max_err got %b want %b", check_err, CE); end
    step();
    n_chk++; if (check_err !== 1'b0) begin n_fail++; $display("FAIL max_err_after got %b want 0", check_err); end
    n_chk++; if (dividend !== 9'd480) begin n_fail++; $display("FAIL max_hold got %0d want 480", dividend); end
  endtask

  task automatic test_div_zero();
    drive(1'b1, 17, 0, 9);
    step();
    drive(1'b0, 0, 0, 0);
    repeat (3) step();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dz_valid got %b want 1", out_valid); end
    n_chk++; if (dividend !== 9'd9) begin n_fail++; $display("FAIL dz_dividend got %0d want 9", dividend); end
    n_chk++; if (check_err !== CE) begin n_fail++; $display("FAIL dz_err got %b want %b", check_err, CE); end
  endtask

  task automatic test_bubble();
    drive(1'b1, 31, 15, 15);
    step();
    drive(1'b0, 5, 5, 5);
    step();
    drive(1'b1, 21, 3, 0);
    step();
    drive(1'b0, 0, 0, 0);
    step();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bub_v0 got %b want 1", out_valid); end
    n_chk++; if (dividend !== 9'd480) begin n_fail++; $display("FAIL bub_d0 got %0d want 480", dividend); end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bub_v1 got %b want 0", out_valid); end
    n_chk++; if (dividend !== 9'd480) begin n_fail++; $display("FAIL bub_hold got %0d want 480", dividend); end
    n_chk++; if (check_err !== 1'b0) begin n_fail++; $display("FAIL bub_err got %b want 0", check_err); end
    step();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bub_v2 got %b want 1", out_valid); end
    n_chk++; if (dividend !== 9'd63) begin n_fail++; $display("FAIL bub_d2 got %0d want 63", dividend); end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 21, 3, 0);
    step();
    drive(1'b1, 12, 5, 3);
    step();
    drive(1'b0, 0, 0, 0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_valid cyc%0d got %b want 0", i, out_valid); end
      n_chk++; if (dividend !== '0) begin n_fail++; $display("FAIL rmf_dividend cyc%0d got %0d want 0", i, dividend); end
      step();
    end
    drive(1'b1, 4, 15, 3);
    step();
    drive(1'b0, 0, 0, 0);
    repeat (2) step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_early got %b want 0", out_valid); end
    step();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmf_new_valid got %b want 1", out_valid); end
    n_chk++; if (dividend !== 9'd63) begin n_fail++; $display("FAIL rmf_new_dividend got %0d want 63", dividend); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_max();
    test_div_zero();
    test_bubble();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
